// File: rtl/nfca_pkg.sv
// Shared definitions for the NFC-A receive path: framer states, FIFO word
// layout and the CRC_A (x^16+x^12+x^5+1, reflected) update.
package nfca_pkg;

  localparam logic [15:0] CRC_A_INIT = 16'h6363;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_FLUSH
  } rx_state_t;

  typedef struct packed {
    logic       tlast;
    logic [3:0] tdatab;
    logic [7:0] tdata;
  } rx_word_t;

  // Bit-serial CRC_A over one byte, LSB first.
  function automatic logic [15:0] crc16(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == '1) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/nfca_rx_fifo.sv
// Byte FIFO for the RX framer: first-word-fall-through, 2**AW entries of
// {tlast, tdatab, tdata}; a write into a full FIFO is accepted only with a read.
module nfca_rx_fifo
  import nfca_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     i_wr,
  input  rx_word_t i_wdata,
  input  logic     i_rd,
  output rx_word_t o_rdata,
  output logic     o_full,
  output logic     o_empty
);

  rx_word_t        r_mem [2**AW];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_cnt;
  logic            w_wr;
  logic            w_rd;

  assign o_full  = r_cnt[AW];
  assign o_empty = (r_cnt == '0);
  assign w_rd    = i_rd && !o_empty;
  assign w_wr    = i_wr && (!o_full || w_rd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  // Empty FIFO presents zeros so stale storage never reaches the bus.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/nfca_rx_frame.sv
// NFC-A receive framer: regroups decoded PICC bits into bytes, checks odd
// parity, accumulates CRC_A, tracks collisions and reports per-frame status.
module nfca_rx_frame
  import nfca_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  remainb,
  input  logic        rx_ien,
  input  logic        rx_ibit,
  input  logic        rx_icol,
  input  logic        rx_iend,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [7:0]  m_tdata,
  output logic [3:0]  m_tdatab,
  output logic        m_tlast,
  output logic        st_valid,
  output logic        st_crc_ok,
  output logic        st_par_err,
  output logic        st_col,
  output logic [11:0] st_col_pos,
  output logic [11:0] st_nbytes,
  output logic        st_overflow
);

  rx_state_t   r_state;
  rx_state_t   w_next;
  logic [3:0]  r_bitpos;
  logic [7:0]  r_shift;
  logic [2:0]  r_rem;
  logic        r_first;
  rx_word_t    r_pend;
  logic        r_pend_v;
  logic [15:0] r_crc;
  logic [11:0] r_bitidx;
  logic [1:0]  r_fph;
  logic [11:0] r_nbytes;
  logic        r_f_par;
  logic        r_f_col;
  logic [11:0] r_f_colpos;
  logic        r_f_ovf;
  logic        r_st_valid;
  logic        r_st_crc_ok;
  logic        r_st_par;
  logic        r_st_col;
  logic [11:0] r_st_colpos;
  logic [11:0] r_st_nbytes;
  logic        r_st_ovf;

  logic        w_wr;
  rx_word_t    w_wdata;
  rx_word_t    w_rdata;
  logic        w_full;
  logic        w_empty;
  logic        w_partial;
  logic [3:0]  w_pbits;
  logic [3:0]  w_fullbits;

  assign w_partial  = (r_bitpos != 4'd0);
  // The first byte of a split frame only owns the bits above remainb.
  assign w_pbits    = r_first ? (r_bitpos - {1'b0, r_rem}) : r_bitpos;
  assign w_fullbits = r_first ? (4'd8 - {1'b0, r_rem}) : 4'd8;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_ien) begin
          if (rx_iend)              w_next = ST_FLUSH;
          else if (remainb == 3'd7) w_next = ST_PARITY;
          else                      w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_iend)                          w_next = ST_FLUSH;
        else if (rx_ien && r_bitpos == 4'd7)  w_next = ST_PARITY;
      end
      ST_PARITY: begin
        if (rx_iend)     w_next = ST_FLUSH;
        else if (rx_ien) w_next = ST_DATA;
      end
      ST_FLUSH: begin
        if (r_fph == 2'd2) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wr    = 1'b0;
    w_wdata = '0;
    case (r_state)
      ST_PARITY: begin
        if (rx_ien && r_pend_v) begin
          w_wr    = 1'b1;
          w_wdata = r_pend;
        end
      end
      ST_FLUSH: begin
        if (r_fph == 2'd0) begin
          w_wr          = r_pend_v;
          w_wdata       = r_pend;
          w_wdata.tlast = !w_partial;
        end else if (r_fph == 2'd1) begin
          w_wr    = w_partial;
          w_wdata = {1'b1, w_pbits, r_shift};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bitpos    <= '0;
      r_shift     <= '0;
      r_rem       <= '0;
      r_first     <= 1'b0;
      r_pend      <= '0;
      r_pend_v    <= 1'b0;
      r_crc       <= CRC_A_INIT;
      r_bitidx    <= '0;
      r_fph       <= '0;
      r_nbytes    <= '0;
      r_f_par     <= 1'b0;
      r_f_col     <= 1'b0;
      r_f_colpos  <= '0;
      r_f_ovf     <= 1'b0;
      r_st_valid  <= 1'b0;
      r_st_crc_ok <= 1'b0;
      r_st_par    <= 1'b0;
      r_st_col    <= 1'b0;
      r_st_colpos <= '0;
      r_st_nbytes <= '0;
      r_st_ovf    <= 1'b0;
    end else begin
      r_st_valid <= 1'b0;
      // nbytes counts every byte the frame produced, including dropped ones.
      if (w_wr) begin
        r_nbytes <= sat_inc12(r_nbytes);
        if (w_full && !m_tready) r_f_ovf <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (rx_ien) begin
            r_rem      <= remainb;
            r_first    <= 1'b1;
            r_shift    <= 8'(rx_ibit) << remainb;
            r_bitpos   <= {1'b0, remainb} + 4'd1;
            r_bitidx   <= 12'(remainb) + 12'd1;
            r_crc      <= CRC_A_INIT;
            r_pend_v   <= 1'b0;
            r_nbytes   <= '0;
            r_fph      <= '0;
            r_f_par    <= 1'b0;
            r_f_ovf    <= 1'b0;
            r_f_col    <= rx_icol;
            r_f_colpos <= rx_icol ? 12'(remainb) : 12'd0;
          end
        end
        ST_DATA: begin
          if (rx_ien) begin
            r_shift[r_bitpos[2:0]] <= rx_ibit;
            r_bitpos <= r_bitpos + 4'd1;
            r_bitidx <= sat_inc12(r_bitidx);
            if (rx_icol && !r_f_col) begin
              r_f_col    <= 1'b1;
              r_f_colpos <= r_bitidx;
            end
          end
        end
        ST_PARITY: begin
          if (rx_ien) begin
            if (!(r_first && r_rem != 3'd0) && (rx_ibit != ~^r_shift)) r_f_par <= 1'b1;
            r_crc    <= crc16(r_crc, r_shift);
            r_pend   <= {1'b0, w_fullbits, r_shift};
            r_pend_v <= 1'b1;
            r_first  <= 1'b0;
            r_bitpos <= '0;
            r_shift  <= '0;
          end
        end
        ST_FLUSH: begin
          r_fph <= r_fph + 2'd1;
          if (r_fph == 2'd0) r_pend_v <= 1'b0;
          if (r_fph == 2'd2) begin
            r_fph       <= '0;
            r_st_valid  <= 1'b1;
            r_st_crc_ok <= (r_crc == 16'h0000) && (r_nbytes >= 12'd3) && !w_partial;
            r_st_par    <= r_f_par;
            r_st_col    <= r_f_col;
            r_st_colpos <= r_f_colpos;
            r_st_nbytes <= r_nbytes;
            r_st_ovf    <= r_f_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  nfca_rx_fifo #(.AW(AW)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_wr    (w_wr),
    .i_wdata (w_wdata),
    .i_rd    (m_tready),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_tvalid    = !w_empty;
  assign m_tdata     = w_rdata.tdata;
  assign m_tdatab    = w_rdata.tdatab;
  assign m_tlast     = w_rdata.tlast;
  assign st_valid    = r_st_valid;
  assign st_crc_ok   = r_st_crc_ok;
  assign st_par_err  = r_st_par;
  assign st_col      = r_st_col;
  assign st_col_pos  = r_st_colpos;
  assign st_nbytes   = r_st_nbytes;
  assign st_overflow = r_st_ovf;

endmodule

// File: tb/tb_nfca_rx_frame.sv
// Bench for nfca_rx_frame: frames are described as byte lists, turned into
// bit streams, and the expected beats/status are derived from the byte lists.
module tb_nfca_rx_frame;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  remainb = 3'd0;
  logic        rx_ien = 1'b0;
  logic        rx_ibit = 1'b0;
  logic        rx_icol = 1'b0;
  logic        rx_iend = 1'b0;
  logic        m_tready = 1'b0;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic [3:0]  m_tdatab;
  logic        m_tlast;
  logic        st_valid;
  logic        st_crc_ok;
  logic        st_par_err;
  logic        st_col;
  logic [11:0] st_col_pos;
  logic [11:0] st_nbytes;
  logic        st_overflow;

  nfca_rx_frame #(.AW(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .remainb    (remainb),
    .rx_ien     (rx_ien),
    .rx_ibit    (rx_ibit),
    .rx_icol    (rx_icol),
    .rx_iend    (rx_iend),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tdatab   (m_tdatab),
    .m_tlast    (m_tlast),
    .st_valid   (st_valid),
    .st_crc_ok  (st_crc_ok),
    .st_par_err (st_par_err),
    .st_col     (st_col),
    .st_col_pos (st_col_pos),
    .st_nbytes  (st_nbytes),
    .st_overflow(st_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observed beats and status strobes, sampled on the falling edge.
  logic [12:0] beat_q[$];
  int          st_cnt = 0;
  logic        cap_crc, cap_par, cap_col, cap_ovf;
  logic [11:0] cap_pos, cap_nb;

  always @(negedge clk) begin
    if (rstn && m_tvalid && m_tready) beat_q.push_back({m_tlast, m_tdatab, m_tdata});
    if (rstn && st_valid) begin
      st_cnt++;
      cap_crc = st_crc_ok;
      cap_par = st_par_err;
      cap_col = st_col;
      cap_pos = st_col_pos;
      cap_nb  = st_nbytes;
      cap_ovf = st_overflow;
    end
  end

  // ISO 14443-3 byte-wise CRC_A update.
  function automatic logic [15:0] crc_a(input logic [15:0] c, input logic [7:0] b);
    logic [7:0] ch;
    ch = b ^ c[7:0];
    ch = ch ^ (ch << 4);
    return (c >> 8) ^ ({8'h00, ch} << 8) ^ ({8'h00, ch} << 3) ^ ({8'h00, ch} >> 4);
  endfunction

  // Frame description: f_n parity-carrying bytes, then f_tb tail bits of f_d[f_n].
  int         f_rem, f_n, f_tb, f_col;
  logic [7:0] f_d [32];
  bit         f_cor [32];
  bit         f_ready, f_simul;

  task automatic set_defaults();
    f_rem = 0; f_n = 0; f_tb = 0; f_col = -1; f_ready = 1'b1; f_simul = 1'b0;
    for (int i = 0; i < 32; i++) begin
      f_d[i] = 8'h00;
      f_cor[i] = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b, input logic c, input logic e);
    int gap;
    rx_ien = 1'b1; rx_ibit = b; rx_icol = c; rx_iend = e;
    @(posedge clk); #1;
    rx_ien = 1'b0; rx_ibit = 1'b0; rx_icol = 1'b0; rx_iend = 1'b0;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_frame(input string name);
    logic [1:0]  bq[$];
    logic [12:0] exp_q[$];
    logic [7:0]  bv, mask, tv;
    logic [15:0] c;
    logic        pb, exp_par, exp_col, exp_ovf, exp_crc;
    int          idx, st, nb, pre;

    idx = f_rem; exp_par = 1'b0; c = 16'h6363;
    for (int k = 0; k < f_n; k++) begin
      st = (k == 0) ? f_rem : 0;
      mask = 8'hFF; mask = mask << st;
      bv = f_d[k] & mask;
      for (int p = st; p < 8; p++) begin
        bq.push_back({bv[p], 1'(idx == f_col || (f_col >= 0 && idx == f_col + 2))});
        idx++;
      end
      pb = ~^bv;
      if (k == 0 && f_rem != 0) pb = 1'($urandom);
      else if (f_cor[k]) begin
        pb = ~pb;
        exp_par = 1'b1;
      end
      bq.push_back({pb, 1'b0});
      c = crc_a(c, bv);
      exp_q.push_back({1'(k == f_n - 1 && f_tb == 0), 4'((k == 0 && f_rem != 0) ? 8 - f_rem : 8), bv});
    end
    if (f_tb > 0) begin
      st = (f_n == 0) ? f_rem : 0;
      tv = 8'h00;
      bv = f_d[f_n];
      for (int p = st; p < st + f_tb; p++) begin
        tv[p] = bv[p];
        bq.push_back({bv[p], 1'(idx == f_col || (f_col >= 0 && idx == f_col + 2))});
        idx++;
      end
      exp_q.push_back({1'b1, 4'(f_tb), tv});
    end
    nb      = f_n + ((f_tb > 0) ? 1 : 0);
    exp_col = (f_col >= 0 && f_col < idx);
    exp_crc = (c == 16'h0000) && (nb >= 3) && (f_tb == 0);
    exp_ovf = !f_ready && (nb > 16);
    if (!f_ready) while (exp_q.size() > 16) void'(exp_q.pop_back());

    beat_q.delete();
    pre = st_cnt;
    m_tready = f_ready;
    remainb = 3'(f_rem);
    for (int i = 0; i < bq.size(); i++) begin
      drive_bit(bq[i][1], bq[i][0], (i == bq.size() - 1) && f_simul);
      if (i == 0) remainb = 3'($urandom);
    end
    if (!f_simul) begin
      rx_iend = 1'b1;
      @(posedge clk); #1;
      rx_iend = 1'b0;
    end
    for (int t = 0; t < 100 && st_cnt == pre; t++) @(posedge clk);
    #1;
    chk({name, ".st_valid_cnt"}, st_cnt - pre, 1);
    chk({name, ".crc_ok"}, cap_crc, exp_crc);
    chk({name, ".par_err"}, cap_par, exp_par);
    chk({name, ".col"}, cap_col, exp_col);
    if (exp_col) chk({name, ".col_pos"}, cap_pos, f_col);
    chk({name, ".nbytes"}, cap_nb, nb);
    chk({name, ".overflow"}, cap_ovf, exp_ovf);

    m_tready = 1'b1;
    for (int t = 0; t < 200 && beat_q.size() < exp_q.size(); t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk({name, ".beats"}, beat_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++)
      chk($sformatf("%s.beat%0d", name, i), beat_q[i], exp_q[i]);
    chk({name, ".nbytes_hold"}, st_nbytes, nb);
  endtask

  initial begin
    int pre;
    int r;
    set_defaults();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outputs", {m_tvalid, m_tdata, m_tdatab, m_tlast, st_valid, st_crc_ok,
                          st_par_err, st_col, st_overflow}, 0);
    chk("reset.status", {st_col_pos, st_nbytes}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // ATQA 44 00
    set_defaults(); f_n = 2; f_d[0] = 8'h44; f_d[1] = 8'h00;
    run_frame("atqa");

    // SAK with valid CRC, then with one data bit flipped (parity still correct)
    set_defaults(); f_n = 3; f_d[0] = 8'h08; f_d[1] = 8'hB6; f_d[2] = 8'hDD;
    run_frame("sak");
    set_defaults(); f_n = 3; f_d[0] = 8'h08; f_d[1] = 8'hB7; f_d[2] = 8'hDD;
    run_frame("sak_bad");

    // 4-bit ACK
    set_defaults(); f_tb = 4; f_d[0] = 8'h0A;
    run_frame("ack");

    // Anticollision, split first byte and a collision on frame bit 3
    set_defaults(); f_rem = 2; f_n = 5; f_d[0] = 8'h34; f_col = 3;
    for (int i = 1; i < 5; i++) f_d[i] = 8'($urandom);
    run_frame("anticol");

    // Overflow with the sink stalled, then a clean frame
    set_defaults(); f_n = 20; f_ready = 1'b0;
    for (int i = 0; i < 20; i++) f_d[i] = 8'($urandom);
    run_frame("ovf");
    set_defaults(); f_n = 3;
    for (int i = 0; i < 3; i++) f_d[i] = 8'($urandom);
    run_frame("post_ovf");

    // Corrupt parity on byte 2
    set_defaults(); f_n = 4;
    for (int i = 0; i < 4; i++) f_d[i] = 8'($urandom);
    f_cor[2] = 1'b1;
    run_frame("par_err");

    // Reset mid-byte
    pre = st_cnt;
    m_tready = 1'b1; remainb = 3'd0;
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom), 1'b0, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midreset.outputs", {m_tvalid, m_tdata, st_valid, st_nbytes}, 0);
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("midreset.no_status", st_cnt - pre, 0);
    set_defaults(); f_n = 3; f_d[0] = 8'h08; f_d[1] = 8'hB6; f_d[2] = 8'hDD;
    run_frame("after_reset");

    // Randomized frames
    for (int fr = 0; fr < 12; fr++) begin
      set_defaults();
      f_rem = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
      f_n = $urandom_range(1, 6);
      r = $urandom_range(0, 3);
      f_tb = (r == 2) ? $urandom_range(1, 7) : (r == 3) ? 8 : 0;
      f_simul = 1'($urandom);
      for (int i = 0; i < 32; i++) f_d[i] = 8'($urandom);
      if (f_rem == 0 && f_tb == 0 && $urandom_range(0, 1) == 1) begin
        logic [15:0] cc;
        cc = 16'h6363;
        for (int i = 0; i < f_n; i++) cc = crc_a(cc, f_d[i]);
        f_d[f_n] = cc[7:0];
        f_d[f_n + 1] = cc[15:8];
        f_n = f_n + 2;
      end else begin
        for (int i = 0; i < f_n; i++) f_cor[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 1) == 1) f_col = $urandom_range(f_rem, 8 * f_n - f_rem + f_tb + f_rem - 1);
      run_frame($sformatf("rnd%0d", fr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nfca_rx_frame.md
Name: nfca_rx_frame

Overview:
- Receive-side framer for the NFC-A (ISO 14443-A) controller; the counterpart of the transmit framer.
- Takes a bit stream (PICC→PCD) already demodulated and Manchester-decoded by the bit decoder, and regroups it into bytes. It checks odd parity per byte, accumulates CRC_A and tracks collisions.
- Delivers bytes on an AXI-stream style master with a per-byte valid-bit count, plus a per-frame status pulse.
- Honours remainb from the TX framer so that bit-oriented anticollision responses are realigned to the split byte.

Parameters:
- AW, 4, output FIFO address width; depth = 2**AW bytes.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- remainb  in  3  bits of the first byte already sent by the PCD; sampled at frame start
- rx_ien  in  1  one-cycle strobe: rx_ibit/rx_icol valid
- rx_ibit  in  1  received bit, LSB-first order
- rx_icol  in  1  collision detected on this bit
- rx_iend  in  1  one-cycle strobe: end of PICC frame (E detected)
- m_tvalid  out  1  output byte valid
- m_tready  in  1  downstream accepts byte
- m_tdata  out  8  received byte, LSB-aligned
- m_tdatab  out  4  valid bits in m_tdata, range 1..8
- m_tlast  out  1  last byte of frame
- st_valid  out  1  one-cycle status strobe per frame
- st_crc_ok  out  1  CRC_A residue check passed
- st_par_err  out  1  at least one parity mismatch
- st_col  out  1  at least one collided bit
- st_col_pos  out  12  frame bit index (data bits only, counting from remainb) of first collision
- st_nbytes  out  12  bytes written for this frame
- st_overflow  out  1  at least one byte dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, crc=16'h6363.
- States:
  - IDLE: first rx_ien enters DATA, bitpos<=remainb, and that bit is processed. rx_iend in IDLE is ignored (empty frame, no status).
  - DATA:
    - Each rx_ien stores rx_ibit at shift[bitpos] and increments bitpos.
    - At bitpos==8 go to PARITY.
    - First collision latches st_col_pos=bit index; st_col flag set.
  - PARITY:
    - Next rx_ien is the parity bit; mismatch vs ~^shift sets par_err.
    - Parity is not checked for the first byte when remainb!=0, because that byte's low bits are PCD-owned and held as 0.
    - crc<=CRC16(crc,shift).
    - The completed byte moves to the pending register. Any previous pending byte is written to the FIFO with tlast=0, tdatab=8.
    - Then return to DATA with bitpos=0.
  - FLUSH: entered on rx_iend from DATA or PARITY.
    - Cycle 1: write pending (if any); tlast=1 only if no partial byte exists.
    - Cycle 2: if bitpos>0, write the partial byte. tdatab=bitpos-remainb for the first byte when remainb!=0, else bitpos. tlast=1.
    - Then drive the status outputs with st_valid=1 for one cycle and return to IDLE.
    - A frame ending in PARITY (8 data bits, no parity) emits the byte with tdatab=8; this is not a parity error.
- Simultaneous rx_ien and rx_iend: the bit is processed first, then FLUSH.
- rx_ien during FLUSH: ignored.
- CRC: st_crc_ok = (crc==0) && nbytes>=3 && no partial byte.
- Status fields hold until the next st_valid.
- Latency: a byte appears in the FIFO 1 cycle after the parity bit of the following byte, or within 2 cycles of rx_iend. m_tvalid follows 1 cycle after the write.
- FIFO:
  - Write when not full. If full, the byte is dropped and st_overflow is set; a dropped tlast byte means no tlast is emitted, and downstream relies on st_valid.
  - Simultaneous read and write when full: the write is accepted.
  - Pointers wrap modulo depth.
- st_nbytes: saturates at 12'hFFF.
- Reset mid-frame: immediate return to IDLE; FIFO flushed; no status.

Decomposition:
- Shared package nfca_pkg holds:
  - CRC16 function and CRC_A init 16'h6363.
  - State encodings IDLE/DATA/PARITY/FLUSH.
  - FIFO word layout {tlast, tdatab[3:0], tdata[7:0]} (13 bits).
- One sub-module, nfca_rx_fifo: synchronous FIFO, parameter AW, 13-bit word, full/empty, first-word-fall-through.

Test Plan:
- ATQA, remainb=0, bits for 44 00 with correct parity, then rx_iend → beats 44(t8), 00(t8,last). Status: nbytes=2, crc_ok=0, par_err=0, col=0.
- SAK 08 B6 DD → 3 beats, last on DD; crc_ok=1. Flip one data bit of B6 with adjusted parity → crc_ok=0.
- 4-bit ACK 0xA, rx_iend right after 4th bit → single beat tdata=0A, tdatab=4, tlast=1; crc_ok=0.
- Anticollision with remainb=2: 6 bits 101100, parity, then 4 full bytes, collision flagged on frame bit 3.
  - First beat tdata=0x34, tdatab=6, par_err=0.
  - st_col=1, st_col_pos=3, nbytes=5.
- m_tready=0, AW=4, 20-byte frame → 16 bytes retained, st_overflow=1. Release m_tready → 16 beats, then a clean next frame with overflow=0.
- Corrupt parity on byte 2 → par_err=1, all bytes still delivered. Reset asserted mid-byte → outputs 0, no st_valid; next frame received correctly.
